mem_access_unit: RTL and testbench

Memory-access stage between the multi-cycle control FSM and a variable-latency 16-bit word memory. Turns the control FSM's per-state memory strobes (IRWrite, MemR, MemW, IoD) into a held request/ready handshake. It owns the instruction register (IR) and memory data register (MDR), and stalls the control FSM until each access completes. A timeout produces a sticky bus error.

---
 rtl/lime_pkg.sv | 22 ++
 rtl/mem_access_unit_if.sv | 22 ++
 rtl/mem_timeout_ctr.sv | 26 ++
 rtl/mem_access_unit.sv | 126 ++++++++++++
 tb/tb_mem_access_unit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/lime_pkg.sv
// rtl/lime_pkg.sv - shared widths, state and access-kind types for the memory-access stage
package lime_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} mau_state_t;

   typedef enum logic [1:0] {ACC_NONE, ACC_FETCH, ACC_READ, ACC_WRITE} access_kind_t;

   // Fetch outranks a data read, which outranks a data write.
   function automatic access_kind_t decode_kind(input logic irw, input logic rd, input logic wr);
      if (irw)
         return ACC_FETCH;
      else if (rd)
         return ACC_READ;
      else if (wr)
         return ACC_WRITE;
      return ACC_NONE;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/ready word-memory bus between the access stage and memory
interface mem_access_unit_if #(
   parameter int DATA_W = lime_pkg::DATA_W,
   parameter int ADDR_W = lime_pkg::ADDR_W
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - 8-bit access watchdog; expired flags the cycle whose count reaches TIMEOUT
module mem_timeout_ctr #(
   parameter int TIMEOUT = 64
) (
   input  logic CLK,
   input  logic Reset,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   logic [7:0] count;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en)
         count <= count + 8'd1;
   end

   // Asserted during the TIMEOUT-th enabled cycle, so the abort lands on that edge.
   assign expired = en && (count == LAST);
endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - holds control-FSM memory strobes as a request/ready access, owns IR and MDR
module mem_access_unit #(
   parameter int DATA_W  = lime_pkg::DATA_W,
   parameter int ADDR_W  = lime_pkg::ADDR_W,
   parameter int TIMEOUT = 64
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              ctl_IRWrite,
   input  logic              ctl_MemR,
   input  logic              ctl_MemW,
   input  logic              ctl_IoD,
   input  logic              ctl_PCWrite,
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] wdata,
   mem_access_unit_if.master mem_bus,
   output logic [DATA_W-1:0] ir_out,
   output logic [DATA_W-1:0] mdr_out,
   output logic              stall,
   output logic              pc_write_en,
   output logic              bus_error
);
   import lime_pkg::*;

   mau_state_t        state_q, state_d;
   access_kind_t      kind_q, kind_d, req_kind;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] ir_d, mdr_d;
   logic              err_d;
   logic              ctr_clr, ctr_en, expired;

   mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
      .CLK     (CLK),
      .Reset   (Reset),
      .clr     (ctr_clr),
      .en      (ctr_en),
      .expired (expired)
   );

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q   <= IDLE;
         kind_q    <= ACC_NONE;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         ir_out    <= '0;
         mdr_out   <= '0;
         bus_error <= 1'b0;
      end else begin
         state_q   <= state_d;
         kind_q    <= kind_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         ir_out    <= ir_d;
         mdr_out   <= mdr_d;
         bus_error <= err_d;
      end
   end

   always_comb begin
      req_kind = decode_kind(ctl_IRWrite, ctl_MemR, ctl_MemW);
      state_d  = state_q;
      kind_d   = kind_q;
      req_d    = req_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      ir_d     = ir_out;
      mdr_d    = mdr_out;
      err_d    = bus_error;
      ctr_clr  = 1'b0;
      ctr_en   = 1'b0;
      stall    = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_kind != ACC_NONE) begin
               stall   = 1'b1;
               kind_d  = req_kind;
               req_d   = 1'b1;
               we_d    = (req_kind == ACC_WRITE);
               addr_d  = ctl_IoD ? alu_addr : pc;
               wdata_d = wdata;
               ctr_clr = 1'b1;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            stall  = 1'b1;
            ctr_en = 1'b1;
            // A ready on the expiry edge still completes normally.
            if (mem_bus.mem_ready) begin
               if (kind_q == ACC_FETCH)
                  ir_d = mem_bus.mem_rdata;
               if (kind_q == ACC_READ)
                  mdr_d = mem_bus.mem_rdata;
               req_d   = 1'b0;
               state_d = DONE;
            end else if (expired) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            // The control FSM is still in its memory state this cycle; its strobes are stale.
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign pc_write_en       = ctl_PCWrite & ~stall;
   assign mem_bus.mem_req   = req_q;
   assign mem_bus.mem_we    = we_q;
   assign mem_bus.mem_addr  = addr_q;
   assign mem_bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - vector table of accesses against a bench-driven memory, plus reset corner sequences
module tb_mem_access_unit;

   typedef struct {
      logic        irw, memr, memw, iod;
      logic [15:0] pc, alu, wd;
      int          wt;
      logic [15:0] rdata, exp_addr;
      logic        exp_we;
      int          exp_acc;
      logic [15:0] exp_ir, exp_mdr;
      logic        exp_err;
   } vec_t;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        ctl_IRWrite, ctl_MemR, ctl_MemW, ctl_IoD, ctl_PCWrite;
   logic [15:0] pc, alu_addr, wdata, ir_out, mdr_out;
   logic        stall, pc_write_en, bus_error;
   int          total = 0;
   int          bad = 0;
   vec_t        vecs[9];

   always #5 CLK = ~CLK;

   mem_access_unit_if bus ();

   mem_access_unit #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(4)) dut (
      .CLK         (CLK),
      .Reset       (Reset),
      .ctl_IRWrite (ctl_IRWrite),
      .ctl_MemR    (ctl_MemR),
      .ctl_MemW    (ctl_MemW),
      .ctl_IoD     (ctl_IoD),
      .ctl_PCWrite (ctl_PCWrite),
      .pc          (pc),
      .alu_addr    (alu_addr),
      .wdata       (wdata),
      .mem_bus     (bus.master),
      .ir_out      (ir_out),
      .mdr_out     (mdr_out),
      .stall       (stall),
      .pc_write_en (pc_write_en),
      .bus_error   (bus_error)
   );

   task automatic chk16(input string n, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", n, act, exp);
      end
   endtask

   task automatic chk1(input string n, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%b required=%b", n, act, exp);
      end
   endtask

   task automatic chki(input string n, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d", n, act, exp);
      end
   endtask

   task automatic strobes_off();
      ctl_IRWrite = 1'b0;
      ctl_MemR    = 1'b0;
      ctl_MemW    = 1'b0;
      ctl_IoD     = 1'b0;
      ctl_PCWrite = 1'b0;
   endtask

   // Called one time unit after a rising edge with the unit in IDLE.
   task automatic run_vec(input int idx, input vec_t v);
      int acc, stalls, pws;
      bit fin;
      acc = 0; stalls = 0; pws = 0; fin = 1'b0;
      ctl_IRWrite = v.irw; ctl_MemR = v.memr; ctl_MemW = v.memw; ctl_IoD = v.iod;
      ctl_PCWrite = v.irw;
      pc = v.pc; alu_addr = v.alu; wdata = v.wd;
      bus.mem_ready = 1'b0; bus.mem_rdata = 16'hDEAD;
      #1;
      chk1($sformatf("v%0d_idle_req", idx), bus.mem_req, 1'b0);
      for (int c = 0; c < 40 && !fin; c++) begin
         if (stall) stalls++;
         if (pc_write_en) pws++;
         if (c > 0 && bus.mem_req) begin
            acc++;
            chk16($sformatf("v%0d_addr", idx), bus.mem_addr, v.exp_addr);
            chk1($sformatf("v%0d_we", idx), bus.mem_we, v.exp_we);
            if (v.exp_we) chk16($sformatf("v%0d_wdata", idx), bus.mem_wdata, v.wd);
            bus.mem_ready = (acc == v.wt);
            bus.mem_rdata = bus.mem_ready ? v.rdata : 16'hDEAD;
         end else if (c > 0) begin
            fin = 1'b1;
            bus.mem_ready = 1'b1;
            bus.mem_rdata = 16'hDEAD;
         end
         @(posedge CLK);
         #2;
      end
      strobes_off();
      bus.mem_ready = 1'b0;
      #1;
      chk1($sformatf("v%0d_finished", idx), fin, 1'b1);
      chki($sformatf("v%0d_access_cycles", idx), acc, v.exp_acc);
      chki($sformatf("v%0d_stall_cycles", idx), stalls, v.exp_acc + 1);
      chki($sformatf("v%0d_pc_write_pulses", idx), pws, v.irw ? 1 : 0);
      chk16($sformatf("v%0d_ir", idx), ir_out, v.exp_ir);
      chk16($sformatf("v%0d_mdr", idx), mdr_out, v.exp_mdr);
      chk1($sformatf("v%0d_bus_error", idx), bus_error, v.exp_err);
      chk1($sformatf("v%0d_idle_stall", idx), stall, 1'b0);
      chk1($sformatf("v%0d_req_dropped", idx), bus.mem_req, 1'b0);
   endtask

   initial begin
      //          irw   memr  memw  iod   pc        alu       wd        wt rdata     addr      we   acc ir        mdr       err
      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1, 16'h1234, 16'h0010, 1'b0, 1, 16'h1234, 16'h0000, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0011, 16'h0200, 16'h0000, 4, 16'hBEEF, 16'h0200, 1'b0, 4, 16'h1234, 16'hBEEF, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0011, 16'h0300, 16'h00AA, 2, 16'h5555, 16'h0300, 1'b1, 2, 16'h1234, 16'hBEEF, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0012, 16'h0400, 16'h0000, 1, 16'h4321, 16'h0012, 1'b0, 1, 16'h4321, 16'hBEEF, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0500, 16'h0000, 3, 16'h0F0F, 16'h0020, 1'b0, 3, 16'h4321, 16'h0F0F, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0021, 16'h0600, 16'h0000, 0, 16'h0000, 16'h0600, 1'b0, 4, 16'h4321, 16'h0F0F, 1'b1};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0013, 16'h0000, 16'h0000, 2, 16'h7777, 16'h0013, 1'b0, 2, 16'h7777, 16'h0F0F, 1'b1};
      vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h1357, 0, 16'h0000, 16'h0030, 1'b1, 4, 16'h7777, 16'h0F0F, 1'b1};
      vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0014, 16'h0700, 16'h0000, 1, 16'h2468, 16'h0700, 1'b0, 1, 16'h2468, 16'h0F0F, 1'b1};

      Reset = 1'b1;
      strobes_off();
      pc = '0; alu_addr = '0; wdata = '0;
      bus.mem_ready = 1'b0; bus.mem_rdata = '0;
      #11;
      chk1("rst_req", bus.mem_req, 1'b0);
      chk1("rst_we", bus.mem_we, 1'b0);
      chk16("rst_addr", bus.mem_addr, 16'h0000);
      chk16("rst_wdata", bus.mem_wdata, 16'h0000);
      chk16("rst_ir", ir_out, 16'h0000);
      chk16("rst_mdr", mdr_out, 16'h0000);
      chk1("rst_bus_error", bus_error, 1'b0);
      #1 Reset = 1'b0;
      @(posedge CLK);
      #1;

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // Ready asserted while idle must not touch IR/MDR or start anything.
      bus.mem_ready = 1'b1; bus.mem_rdata = 16'hCAFE;
      repeat (3) @(posedge CLK);
      #1;
      chk1("idle_ready_req", bus.mem_req, 1'b0);
      chk1("idle_ready_stall", stall, 1'b0);
      chk16("idle_ready_ir", ir_out, 16'h2468);
      chk16("idle_ready_mdr", mdr_out, 16'h0F0F);
      bus.mem_ready = 1'b0;

      // Reset landing in the second ACCESS cycle.
      ctl_IRWrite = 1'b1; ctl_PCWrite = 1'b1; ctl_IoD = 1'b0; pc = 16'h0044;
      @(posedge CLK); #1;
      chk1("mid_acc1_req", bus.mem_req, 1'b1);
      @(posedge CLK); #1;
      chk1("mid_acc2_req", bus.mem_req, 1'b1);
      Reset = 1'b1;
      #1;
      chk1("mid_rst_req", bus.mem_req, 1'b0);
      chk16("mid_rst_addr", bus.mem_addr, 16'h0000);
      chk16("mid_rst_ir", ir_out, 16'h0000);
      chk16("mid_rst_mdr", mdr_out, 16'h0000);
      chk1("mid_rst_bus_error", bus_error, 1'b0);
      strobes_off();
      @(posedge CLK); #3;
      Reset = 1'b0;
      #1;
      chk1("post_rst_idle_stall", stall, 1'b0);
      ctl_IRWrite = 1'b1; ctl_PCWrite = 1'b1;
      #1;
      chk1("post_rst_req_stall", stall, 1'b1);
      chk1("post_rst_pcw", pc_write_en, 1'b0);
      chk1("post_rst_req_low", bus.mem_req, 1'b0);
      @(posedge CLK); #1;
      chk1("post_rst_access_req", bus.mem_req, 1'b1);
      chk16("post_rst_access_addr", bus.mem_addr, 16'h0044);
      bus.mem_ready = 1'b1; bus.mem_rdata = 16'h9999;
      @(posedge CLK); #1;
      chk16("post_rst_ir", ir_out, 16'h9999);
      chk1("post_rst_done_req", bus.mem_req, 1'b0);
      chk1("post_rst_done_pcw", pc_write_en, 1'b1);
      strobes_off();
      bus.mem_ready = 1'b0;
      @(posedge CLK); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
